// File: rtl/morse_key_decoder.sv
// Straight-key Morse decoder: times key-down/key-up in ticks, classifies dot/dash, emits 6-bit codes.
// Optional word-space detection (code 37) is enabled by defining WORD_GAP_EN.
module morse_key_decoder #(
  parameter int MAX_ELEMS  = 5,
  parameter int CNT_W      = 8,
  parameter int DASH_TICKS = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       key,
  output logic [5:0] char_out,
  output logic       char_valid,
  output logic       elem_valid,
  output logic       elem_dash
);

  localparam int LEN_W = $clog2(MAX_ELEMS + 1);
  localparam logic [5:0] CODE_INVALID = 6'd36;
  localparam logic [5:0] CODE_SPACE   = 6'd37;

  if (MAX_ELEMS < 5) begin : g_bad_max_elems
    $error("morse_key_decoder: MAX_ELEMS must be at least 5");
  end
  if (DASH_TICKS < 1 || LETTER_GAP < 1) begin : g_bad_timing
    $error("morse_key_decoder: DASH_TICKS and LETTER_GAP must be at least 1");
  end
  if (WORD_GAP <= LETTER_GAP) begin : g_bad_word_gap
    $error("morse_key_decoder: WORD_GAP must exceed LETTER_GAP");
  end

`ifdef WORD_GAP_EN
  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORD_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
`endif

  state_t                 state_reg;
  logic [CNT_W-1:0]       mark_cnt_reg;
  logic [CNT_W-1:0]       gap_cnt_reg;
  logic [MAX_ELEMS-1:0]   elems_reg;
  logic [LEN_W-1:0]       len_reg;
  logic                   ovf_reg;
  logic                   from_space_reg;
  logic [5:0]             char_out_reg;
  logic                   char_valid_reg;
  logic                   elem_valid_reg;
  logic                   elem_dash_reg;

  logic                   is_dash;
  logic [CNT_W-1:0]       gap_next;

  assign is_dash  = (mark_cnt_reg >= CNT_W'(DASH_TICKS));
  assign gap_next = (gap_cnt_reg == '1) ? gap_cnt_reg : gap_cnt_reg + CNT_W'(1);

  // Pattern holds the first element in bit len-1; dash = 1.
  function automatic logic [5:0] decode(input int len, input logic [4:0] pat, input logic ovf);
    logic [5:0] code;
    code = CODE_INVALID;
    if (!ovf) begin
      case (len)
        1: code = pat[0] ? 6'd29 : 6'd14;
        2: case (pat[1:0])
             2'b01: code = 6'd10;
             2'b00: code = 6'd18;
             2'b11: code = 6'd22;
             default: code = 6'd23;
           endcase
        3: case (pat[2:0])
             3'b100: code = 6'd13;
             3'b110: code = 6'd16;
             3'b101: code = 6'd20;
             3'b111: code = 6'd24;
             3'b010: code = 6'd27;
             3'b000: code = 6'd28;
             3'b001: code = 6'd30;
             default: code = 6'd32;
           endcase
        4: case (pat[3:0])
             4'b1000: code = 6'd11;
             4'b1010: code = 6'd12;
             4'b0010: code = 6'd15;
             4'b0000: code = 6'd17;
             4'b0111: code = 6'd19;
             4'b0100: code = 6'd21;
             4'b0110: code = 6'd25;
             4'b1101: code = 6'd26;
             4'b0001: code = 6'd31;
             4'b1001: code = 6'd33;
             4'b1011: code = 6'd34;
             4'b1100: code = 6'd35;
             default: code = CODE_INVALID;
           endcase
        5: case (pat)
             5'b11111: code = 6'd0;
             5'b01111: code = 6'd1;
             5'b00111: code = 6'd2;
             5'b00011: code = 6'd3;
             5'b00001: code = 6'd4;
             5'b00000: code = 6'd5;
             5'b10000: code = 6'd6;
             5'b11000: code = 6'd7;
             5'b11100: code = 6'd8;
             5'b11110: code = 6'd9;
             default:  code = CODE_INVALID;
           endcase
        default: code = CODE_INVALID;
      endcase
    end
    return code;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= IDLE;
      mark_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      elems_reg      <= '0;
      len_reg        <= '0;
      ovf_reg        <= 1'b0;
      from_space_reg <= 1'b0;
      char_out_reg   <= CODE_INVALID;
      char_valid_reg <= 1'b0;
      elem_valid_reg <= 1'b0;
      elem_dash_reg  <= 1'b0;
    end else begin
      char_valid_reg <= 1'b0;
      elem_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (key) begin
            state_reg      <= MARK;
            mark_cnt_reg   <= '0;
            from_space_reg <= 1'b0;
          end
        end
        MARK: begin
          if (!key) begin
            if (mark_cnt_reg == '0) begin
              // Zero-tick press: drop it and resume where we came from.
              if (from_space_reg) begin
                state_reg   <= SPACE;
                gap_cnt_reg <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              elem_valid_reg <= 1'b1;
              elem_dash_reg  <= is_dash;
              if (len_reg < LEN_W'(MAX_ELEMS)) begin
                elems_reg <= {elems_reg[MAX_ELEMS-2:0], is_dash};
                len_reg   <= len_reg + LEN_W'(1);
              end else begin
                ovf_reg <= 1'b1;
              end
              state_reg   <= SPACE;
              gap_cnt_reg <= '0;
            end
          end else if (tick && mark_cnt_reg != '1) begin
            mark_cnt_reg <= mark_cnt_reg + CNT_W'(1);
          end
        end
        SPACE: begin
          if (key) begin
            state_reg      <= MARK;
            mark_cnt_reg   <= '0;
            from_space_reg <= 1'b1;
          end else if (tick) begin
            gap_cnt_reg <= gap_next;
            if (gap_next == CNT_W'(LETTER_GAP)) begin
              char_out_reg   <= decode(int'(len_reg), elems_reg[4:0], ovf_reg);
              char_valid_reg <= 1'b1;
              elems_reg      <= '0;
              len_reg        <= '0;
              ovf_reg        <= 1'b0;
`ifdef WORD_GAP_EN
              state_reg      <= WORD_WAIT;
`else
              state_reg      <= IDLE;
`endif
            end
          end
        end
`ifdef WORD_GAP_EN
        WORD_WAIT: begin
          if (key) begin
            state_reg      <= MARK;
            mark_cnt_reg   <= '0;
            from_space_reg <= 1'b0;
          end else if (tick) begin
            gap_cnt_reg <= gap_next;
            if (gap_next == CNT_W'(WORD_GAP)) begin
              char_out_reg   <= CODE_SPACE;
              char_valid_reg <= 1'b1;
              state_reg      <= IDLE;
            end
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign char_out   = char_out_reg;
  assign char_valid = char_valid_reg;
  assign elem_valid = elem_valid_reg;
  assign elem_dash  = elem_dash_reg;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder: directed key patterns push expected elements/codes,
// a negedge monitor pops and compares whenever elem_valid or char_valid pulses.
module tb_morse_key_decoder;

  localparam int LETTER_GAP = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       tick;
  logic       key;
  logic [5:0] char_out;
  logic       char_valid;
  logic       elem_valid;
  logic       elem_dash;

  int         total  = 0;
  int         passed = 0;
  bit         exp_elem_q[$];
  logic [5:0] exp_char_q[$];
  logic [5:0] last_code;

  morse_key_decoder #(
    .MAX_ELEMS(5), .CNT_W(8), .DASH_TICKS(3), .LETTER_GAP(LETTER_GAP), .WORD_GAP(7)
  ) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .key(key),
    .char_out(char_out), .char_valid(char_valid),
    .elem_valid(elem_valid), .elem_dash(elem_dash)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin : monitor
    bit         e;
    logic [5:0] c;
    forever begin
      @(negedge Clock);
      if (elem_valid) begin
        if (exp_elem_q.size() == 0) chk("elem_unexpected", 1, 0);
        else begin
          e = exp_elem_q.pop_front();
          $display("elem: dash=%0d expected=%0d", elem_dash, e);
          chk("elem_dash", int'(elem_dash), int'(e));
        end
      end
      if (char_valid) begin
        if (exp_char_q.size() == 0) chk("char_unexpected", int'(char_out), -1);
        else begin
          c = exp_char_q.pop_front();
          $display("char: code=%0d expected=%0d", char_out, c);
          chk("char_out", int'(char_out), int'(c));
        end
      end
    end
  end

  task automatic step(input bit k, input bit t);
    key  = k;
    tick = t;
    @(posedge Clock);
    #1;
  endtask

  // Key down for n ticks: the first key-down cycle only moves the FSM into MARK.
  task automatic mark(input int n, input bit d);
    for (int i = 0; i < n + 1; i++) step(1'b1, 1'b1);
    exp_elem_q.push_back(d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n + 1; i++) step(1'b0, 1'b1);
  endtask

  task automatic end_char(input logic [5:0] code);
    exp_char_q.push_back(code);
    last_code = code;
    for (int i = 0; i < LETTER_GAP + 2; i++) step(1'b0, 1'b1);
  endtask

  task automatic send(input string s, input logic [5:0] code);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") mark(3, 1'b1);
      else mark(1, 1'b0);
      if (i != s.len() - 1) gap(1);
    end
    end_char(code);
  endtask

  initial begin : stimulus
    Reset = 1'b1;
    key   = 1'b1;
    tick  = 1'b1;
    last_code = 6'd36;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_char_out", int'(char_out), 36);
    chk("reset_char_valid", int'(char_valid), 0);
    chk("reset_elem_valid", int'(elem_valid), 0);
    key   = 1'b0;
    Reset = 1'b0;
    step(1'b0, 1'b1);

    send(".-", 6'd10);
    send("-----", 6'd0);
    send("----.", 6'd9);
    send("......", 6'd36);
    send("..--", 6'd36);
    send(".", 6'd14);
    send("-", 6'd29);
    send("--..", 6'd35);
    send(".....", 6'd5);

    // Two-tick presses sit just under the dash threshold: "I".
    mark(2, 1'b0);
    gap(1);
    mark(2, 1'b0);
    end_char(6'd18);

    // Zero-tick blip in the gap is discarded and restarts the gap count: still "E".
    mark(1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    end_char(6'd14);

    // Key held with tick frozen: no element may be produced.
    repeat (4) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    // Reset mid-gap discards the partial character.
    mark(1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    Reset = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    Reset = 1'b0;
    repeat (10) step(1'b0, 1'b1);
    last_code = 6'd36;
    chk("reset_mid_gap_char_out", int'(char_out), 36);

    // Long key-up after "E": word space follows only with word-gap detection.
    mark(1, 1'b0);
    exp_char_q.push_back(6'd14);
    last_code = 6'd14;
`ifdef WORD_GAP_EN
    exp_char_q.push_back(6'd37);
    last_code = 6'd37;
`endif
    repeat (15) step(1'b0, 1'b1);

    for (int i = 0; i < 50 && (exp_elem_q.size() != 0 || exp_char_q.size() != 0); i++)
      step(1'b0, 1'b1);
    chk("elem_queue_drained", exp_elem_q.size(), 0);
    chk("char_queue_drained", exp_char_q.size(), 0);
    chk("char_out_hold", int'(char_out), int'(last_code));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Timing-based Morse decoder that sits between a debounced straight-key input and the character consumer. It replaces the pre-classified dot/dash front end: the block measures key-down and key-up durations against a tick timebase and classifies each element as a dot or a dash. It collects up to MAX_ELEMS elements per character and emits one 6-bit character code per letter with a single-cycle valid strobe. Codes use the existing character map: 0-9 = digits, 10-35 = A-Z, 36 = invalid.

## Interface
- MAX_ELEMS, 5: element capacity per character; must be ≥5.
- CNT_W, 8: width of the mark and gap counters; counters saturate at all-ones.
- DASH_TICKS, 3: a key-down of at least this many ticks is a dash; 1 to DASH_TICKS-1 ticks is a dot.
- LETTER_GAP, 3: key-up ticks that end a character.
- WORD_GAP, 7: key-up ticks that end a word (WORD_GAP_EN only); must be > LETTER_GAP.
- Clock  in  1  system clock.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clock.
- tick  in  1  timebase strobe, one cycle wide; all durations are counted in ticks.
- key  in  1  key level, 1 = down; already synchronised and debounced upstream.
- char_out  out  6  last emitted character code.
- char_valid  out  1  one-cycle pulse when char_out is updated.
- elem_valid  out  1  one-cycle pulse per accepted element.
- elem_dash  out  1  class of the last element, 1 = dash; valid with elem_valid.

## Operation
- Element storage: a MAX_ELEMS-bit shift register, plus a length counter len and a sticky ovf flag.
  - Each new element shifts in at the LSB, dash = 1, so the first element ends up in the MSB of the len-bit pattern.
- FSM states: IDLE, MARK, SPACE, and WORD_WAIT (WORD_WAIT exists only with WORD_GAP_EN).
- IDLE:
  - key=1 → MARK, mark_cnt cleared.
- MARK:
  - mark_cnt increments on tick.
  - key=0 with mark_cnt=0 is a glitch: discard it and return to the prior state (IDLE, or SPACE with gap_cnt cleared).
  - key=0 with mark_cnt≥1 classifies the element (dash iff mark_cnt≥DASH_TICKS) and pulses elem_valid/elem_dash.
  - The element is appended if len<MAX_ELEMS; otherwise ovf is set. Then → SPACE with gap_cnt cleared.
- SPACE:
  - gap_cnt increments on tick.
  - key=1 → MARK; the element joins the same character and nothing is emitted. key=1 has priority over gap completion in the same cycle.
  - The tick that brings gap_cnt to LETTER_GAP emits the character, clears the element register, len and ovf, and goes → IDLE (→ WORD_WAIT with WORD_GAP_EN).
- Decode of (len, pattern):
  - len 1-4 letters: A=01 → 10, E=0 → 14, T=1 → 29, …, Z=1100 → 35.
  - len 5 digits: 11111 → 0, 01111 → 1, …, 11110 → 9.
  - Any unmatched pattern, len>5, or ovf=1 → 36.
- Reset mid-character discards partial state; no char_valid is generated.

## Timing
- Reset values:
  - FSM = IDLE; counters, len, ovf and element register = 0.
  - char_out = 36; char_valid = 0; elem_valid = 0; elem_dash = 0.
- All outputs are registered.
- elem_valid rises the cycle after the cycle in which key=0 is first sampled in MARK.
- char_valid is high exactly one cycle, the cycle after the completing tick. char_out changes on that same edge and holds until the next emission.
- Back-to-back characters are spaced at least LETTER_GAP+1 ticks apart, so char_valid never asserts on consecutive cycles.
- tick=0 throughout freezes all counters; key edges are still tracked.

## Configuration
- WORD_GAP_EN defined:
  - WORD_WAIT keeps counting gap_cnt from LETTER_GAP.
  - On reaching WORD_GAP, the block emits code 37 (word space) with char_valid and goes → IDLE.
  - key=1 in WORD_WAIT → MARK; no space is emitted.
- WORD_GAP_EN undefined: the WORD_WAIT state and code 37 do not exist, and WORD_GAP is ignored.

## Test plan
- Reset with key=1 and tick=1 → char_out=36, char_valid=0, elem_valid=0; the FSM leaves IDLE only after Reset drops.
- tick every cycle; key down 1, up 1, down 3, up 3 ticks → elem pulses dot then dash, then one char_valid with char_out=10 (A).
- Five 3-tick dashes with 1-tick gaps, then a 3-tick gap → char_out=0. Repeat with the last element a 1-tick dot → char_out=9.
- Six 1-tick dots → ovf set, char_out=36. "..--" → char_out=36.
- key high for 4 cycles while tick=0 → no elem_valid. Key down 1 tick, then Reset asserted mid-gap → no char_valid, char_out stays 36.
- WORD_GAP_EN: "E", then key up 7 ticks → char_out=14, then 4 ticks later char_out=37. Without WORD_GAP_EN → only 14.
